// File: rtl/sap2_boot_ctl.sv
// ---------------------------------------------------------------------------
// sap2_boot_ctl
//
// Boot/run sequencer for the sap2_mini CPU. A boot first clears the CPU. It
// then streams the host program into CPU memory over a valid/ready handshake,
// driving prog/a/d. It clears the CPU a second time to release it, lets it
// run for a fixed window, and captures the CPU output word as the result.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   clr_n     in   asynchronous active-low reset
//   start     in   one-cycle pulse, begins a boot from IDLE or DONE
//   abort     in   one-cycle pulse, returns to IDLE from any state
//   wr_valid  in   host program word valid
//   wr_data   in   host program word
//   wr_last   in   marks the final word of the program
//   wr_ready  out  controller accepts a word this cycle
//   cpu_out   in   CPU output register
//   prog      out  CPU programming enable
//   a         out  CPU program address
//   d         out  CPU program data
//   cpu_clr   out  CPU clear (active high)
//   busy      out  high in every state except IDLE and DONE
//   done      out  high in DONE
//   err       out  sticky address-overflow flag, cleared by the next start
//   result    out  cpu_out sampled on the last cycle of the run window
// ---------------------------------------------------------------------------
module sap2_boot_ctl #(
   parameter int AW         = 8,
   parameter int DW         = 12,
   parameter int CLR_CYCLES = 2,
   parameter int HOLD       = 2,
   parameter int RUN_CYCLES = 240
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          start,
   input  logic          abort,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_last,
   output logic          wr_ready,
   input  logic [DW-1:0] cpu_out,
   output logic          prog,
   output logic [AW-1:0] a,
   output logic [DW-1:0] d,
   output logic          cpu_clr,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] result
);

   // One phase counter serves every timed phase. It is sized for the longest
   // phase, so it cannot wrap before a phase ends.
   localparam int MAX_A = (CLR_CYCLES > HOLD) ? CLR_CYCLES : HOLD;
   localparam int MAXC  = (MAX_A > RUN_CYCLES) ? MAX_A : RUN_CYCLES;
   localparam int CW    = (MAXC < 2) ? 1 : $clog2(MAXC);

   localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
   localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);

   typedef enum logic [2:0] {
      st_idle,
      st_clr0,
      st_ld_wait,
      st_ld_hold,
      st_clr1,
      st_run,
      st_done
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last_q;

   // Sequencer. Every output is a register. Each output is written on the
   // edge that enters the state it belongs to, so it is already valid during
   // the first cycle of that state.
   //
   // Each timed phase starts with the counter at zero. The phase ends on the
   // edge where the counter reaches its terminal value, which gives exactly
   // N cycles in that state.
   //
   // Abort overrides everything except reset. It drops any word that is in
   // flight. It leaves result and err untouched so the host can still read
   // them after an abort.
   //
   // The address only advances once a word has finished its hold time. So
   // word k lands at address k. Overflow is detected when a word at the top
   // address finishes without wr_last.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= st_idle;
         cnt      <= '0;
         last_q   <= 1'b0;
         prog     <= 1'b0;
         a        <= '0;
         d        <= '0;
         cpu_clr  <= 1'b0;
         wr_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         result   <= '0;
      end else if (abort) begin
         state    <= st_idle;
         cnt      <= '0;
         last_q   <= 1'b0;
         prog     <= 1'b0;
         a        <= '0;
         d        <= '0;
         cpu_clr  <= 1'b0;
         wr_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            st_idle, st_done: begin
               if (start) begin
                  state   <= st_clr0;
                  cnt     <= '0;
                  last_q  <= 1'b0;
                  err     <= 1'b0;
                  a       <= '0;
                  d       <= '0;
                  prog    <= 1'b0;
                  cpu_clr <= 1'b1;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end

            st_clr0: begin
               if (cnt == CLR_LAST) begin
                  state    <= st_ld_wait;
                  cnt      <= '0;
                  cpu_clr  <= 1'b0;
                  prog     <= 1'b1;
                  wr_ready <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            st_ld_wait: begin
               if (wr_valid && wr_ready) begin
                  state    <= st_ld_hold;
                  cnt      <= '0;
                  d        <= wr_data;
                  last_q   <= wr_last;
                  wr_ready <= 1'b0;
               end
            end

            st_ld_hold: begin
               if (cnt == HOLD_LAST) begin
                  cnt <= '0;
                  if (last_q) begin
                     state   <= st_clr1;
                     prog    <= 1'b0;
                     cpu_clr <= 1'b1;
                     a       <= '0;
                     d       <= '0;
                  end else if (a == '1) begin
                     state <= st_idle;
                     err   <= 1'b1;
                     prog  <= 1'b0;
                     busy  <= 1'b0;
                     a     <= '0;
                     d     <= '0;
                  end else begin
                     state    <= st_ld_wait;
                     a        <= a + 1'b1;
                     wr_ready <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            st_clr1: begin
               if (cnt == CLR_LAST) begin
                  state   <= st_run;
                  cnt     <= '0;
                  cpu_clr <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            st_run: begin
               if (cnt == RUN_LAST) begin
                  state  <= st_done;
                  cnt    <= '0;
                  result <= cpu_out;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state    <= st_idle;
               cnt      <= '0;
               prog     <= 1'b0;
               cpu_clr  <= 1'b0;
               wr_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule
